// File: rtl/rc5_pkg.sv
// Shared types, constants and W-generic rotate helpers for the RC5 cipher core.
// Rotates operate on a 64-bit carrier masked down to the live word width.
package rc5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Magic constants Pw/Qw used by the RC5 key schedule.
    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E1_5163;
    localparam logic [31:0] Q32 = 32'h9E37_79B9;
    localparam logic [63:0] P64 = 64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] Q64 = 64'h9E37_79B9_7F4A_7C15;

    function automatic logic [63:0] width_mask(input int unsigned w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // w must be a power of two; only the low log2(w) bits of amt matter.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned amt,
                                         input int unsigned w);
        logic [63:0] m;
        int unsigned s;
        m = width_mask(w);
        s = amt & (w - 1);
        if (s == 0)
            return x & m;
        return ((x << s) | ((x & m) >> (w - s))) & m;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned amt,
                                         input int unsigned w);
        logic [63:0] m;
        int unsigned s;
        m = width_mask(w);
        s = amt & (w - 1);
        if (s == 0)
            return x & m;
        return (((x & m) >> s) | (x << (w - s))) & m;
    endfunction

endpackage

// File: rtl/rc5_round_unit.sv
// One full RC5 round (both half-rounds), combinational, for either direction.
module rc5_round_unit
    import rc5_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s_even,
    input  logic [W-1:0] s_odd,
    input  logic         mode,
    output logic [W-1:0] a_next,
    output logic [W-1:0] b_next
);

    localparam int LW = $clog2(W);

    logic [W-1:0] enc_a;
    logic [W-1:0] enc_b;
    logic [W-1:0] dec_a;
    logic [W-1:0] dec_b;
    logic [W-1:0] b_minus;
    logic [W-1:0] a_minus;

    assign enc_a = W'(rotl(64'(a ^ b), 32'(b[LW-1:0]), W)) + s_even;
    assign enc_b = W'(rotl(64'(b ^ enc_a), 32'(enc_a[LW-1:0]), W)) + s_odd;

    // Decrypt undoes B first, since A's rotate amount is the recovered B.
    assign b_minus = b - s_odd;
    assign dec_b   = W'(rotr(64'(b_minus), 32'(a[LW-1:0]), W)) ^ a;
    assign a_minus = a - s_even;
    assign dec_a   = W'(rotr(64'(a_minus), 32'(dec_b[LW-1:0]), W)) ^ dec_b;

    assign a_next = (mode == MODE_DEC) ? dec_a : enc_a;
    assign b_next = (mode == MODE_DEC) ? dec_b : enc_b;

endmodule

// File: rtl/rc5_cipher_core.sv
// Iterative RC5-W/R encrypt/decrypt engine with a run-time writable key table
// and valid/ready handshakes on input and output.
module rc5_cipher_core
    import rc5_pkg::*;
#(
    parameter  int W  = 32,
    parameter  int R  = 12,
    localparam int T  = 2 * R + 2,
    localparam int AW = $clog2(T)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          key_we,
    input  logic [AW-1:0] key_addr,
    input  logic [W-1:0]  key_wdata,
    output logic          key_wr_err,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          din_mode,
    input  logic [2*W-1:0] din,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [2*W-1:0] dout,
    output logic          busy
);

    localparam logic [AW:0] T_LIM = (AW + 1)'(T);
    localparam logic [8:0]  LAST  = 9'(R);

    state_e       state_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [8:0]   rnd_reg;
    logic         mode_reg;
    logic         started_reg;
    logic         key_wr_err_reg;

    logic [W-1:0]  key_mem [T];
    logic          key_wr;
    logic [AW-1:0] idx_even;
    logic [AW-1:0] idx_odd;
    logic [W-1:0]  a_next;
    logic [W-1:0]  b_next;

    assign key_wr = key_we && (state_reg == IDLE) && ({1'b0, key_addr} < T_LIM);

    // Every entry clears on reset, so the table lives in flops, not block RAM.
    for (genvar gi = 0; gi < T; gi++) begin : g_key
        logic [W-1:0] entry_reg;
        always_ff @(posedge clk or negedge clr) begin
            if (!clr)
                entry_reg <= '0;
            else if (key_wr && key_addr == AW'(gi))
                entry_reg <= key_wdata;
        end
        assign key_mem[gi] = entry_reg;
    end

    // rnd_reg stays within 0..R, so both indices are always inside the table.
    assign idx_even = AW'({rnd_reg, 1'b0});
    assign idx_odd  = AW'({rnd_reg, 1'b1});

    rc5_round_unit #(.W(W)) u_round (
        .a      (a_reg),
        .b      (b_reg),
        .s_even (key_mem[idx_even]),
        .s_odd  (key_mem[idx_odd]),
        .mode   (mode_reg),
        .a_next (a_next),
        .b_next (b_next)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            rnd_reg        <= '0;
            mode_reg       <= MODE_ENC;
            started_reg    <= 1'b0;
            key_wr_err_reg <= 1'b0;
        end else begin
            started_reg    <= 1'b1;
            key_wr_err_reg <= key_we && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (din_valid && din_ready) begin
                        mode_reg  <= din_mode;
                        state_reg <= ROUND;
                        if (din_mode == MODE_ENC) begin
                            a_reg   <= din[2*W-1:W] + key_mem[0];
                            b_reg   <= din[W-1:0] + key_mem[1];
                            rnd_reg <= 9'd1;
                        end else begin
                            a_reg   <= din[2*W-1:W];
                            b_reg   <= din[W-1:0];
                            rnd_reg <= LAST;
                        end
                    end
                end
                ROUND: begin
                    a_reg <= a_next;
                    b_reg <= b_next;
                    if (mode_reg == MODE_ENC) begin
                        if (rnd_reg == LAST)
                            state_reg <= DONE;
                        else
                            rnd_reg <= rnd_reg + 9'd1;
                    end else begin
                        rnd_reg <= rnd_reg - 9'd1;
                        if (rnd_reg == 9'd1)
                            state_reg <= POST;
                    end
                end
                POST: begin
                    a_reg     <= a_reg - key_mem[0];
                    b_reg     <= b_reg - key_mem[1];
                    state_reg <= DONE;
                end
                DONE: begin
                    if (dout_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign din_ready  = started_reg && (state_reg == IDLE);
    assign dout_valid = (state_reg == DONE);
    assign dout       = (state_reg == DONE) ? {a_reg, b_reg} : '0;
    assign busy       = (state_reg != IDLE);
    assign key_wr_err = key_wr_err_reg;

endmodule

// File: tb/tb_rc5_cipher_core.sv
// Self-checking bench for rc5_cipher_core: W=32/R=12 main instance plus a
// W=16/R=8 instance, checked against a loop-level RC5 reference model.
module tb_rc5_cipher_core;
    import rc5_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b0;

    logic        key_we = 1'b0;
    logic [4:0]  key_addr = '0;
    logic [31:0] key_wdata = '0;
    logic        key_wr_err;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        din_mode = 1'b0;
    logic [63:0] din = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [63:0] dout;
    logic        busy;

    logic        k16_we = 1'b0;
    logic [4:0]  k16_addr = '0;
    logic [15:0] k16_wdata = '0;
    logic        k16_err;
    logic        d16_valid = 1'b0;
    logic        d16_ready;
    logic        d16_mode = 1'b0;
    logic [31:0] d16_in = '0;
    logic        q16_valid;
    logic        q16_ready = 1'b0;
    logic [31:0] q16;
    logic        busy16;

    int checks = 0;
    int failures = 0;

    longint unsigned ks32 [0:25];
    longint unsigned ks16 [0:17];

    always #5 clk = ~clk;

    rc5_cipher_core #(.W(32), .R(12)) dut (
        .clk(clk), .clr(clr),
        .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata), .key_wr_err(key_wr_err),
        .din_valid(din_valid), .din_ready(din_ready), .din_mode(din_mode), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .busy(busy)
    );

    rc5_cipher_core #(.W(16), .R(8)) dut16 (
        .clk(clk), .clr(clr),
        .key_we(k16_we), .key_addr(k16_addr), .key_wdata(k16_wdata), .key_wr_err(k16_err),
        .din_valid(d16_valid), .din_ready(d16_ready), .din_mode(d16_mode), .din(d16_in),
        .dout_valid(q16_valid), .dout_ready(q16_ready), .dout(q16), .busy(busy16)
    );

    // ---------------- reference model ----------------
    function automatic longint unsigned msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned rol(input longint unsigned x, input longint unsigned s, input int w);
        int sh = int'(s % longint'(w));
        longint unsigned xm = x & msk(w);
        if (sh == 0) return xm;
        return ((xm << sh) | (xm >> (w - sh))) & msk(w);
    endfunction

    function automatic longint unsigned ror(input longint unsigned x, input longint unsigned s, input int w);
        int sh = int'(s % longint'(w));
        longint unsigned xm = x & msk(w);
        if (sh == 0) return xm;
        return ((xm >> sh) | (xm << (w - sh))) & msk(w);
    endfunction

    function automatic longint unsigned sk(input int k, input int w);
        if (w == 16) return ks16[k];
        return ks32[k];
    endfunction

    function automatic longint unsigned enc_model(input longint unsigned blk, input int w, input int r);
        longint unsigned m = msk(w);
        longint unsigned a = (blk >> w) & m;
        longint unsigned b = blk & m;
        a = (a + sk(0, w)) & m;
        b = (b + sk(1, w)) & m;
        for (int i = 1; i <= r; i++) begin
            a = (rol(a ^ b, b, w) + sk(2 * i, w)) & m;
            b = (rol(b ^ a, a, w) + sk(2 * i + 1, w)) & m;
        end
        return (a << w) | b;
    endfunction

    function automatic longint unsigned dec_model(input longint unsigned blk, input int w, input int r);
        longint unsigned m = msk(w);
        longint unsigned a = (blk >> w) & m;
        longint unsigned b = blk & m;
        for (int i = r; i >= 1; i--) begin
            b = ror((b - sk(2 * i + 1, w)) & m, a, w) ^ a;
            a = ror((a - sk(2 * i, w)) & m, b, w) ^ b;
        end
        b = (b - sk(1, w)) & m;
        a = (a - sk(0, w)) & m;
        return (a << w) | b;
    endfunction

    // RC5-32/12 key schedule for a 16-byte all-zero key (c = 4 words).
    task automatic expand_zero_key32();
        longint unsigned l [0:3];
        longint unsigned a = 0, b = 0;
        int i = 0, j = 0;
        longint unsigned m = msk(32);
        for (int k = 0; k < 4; k++) l[k] = 0;
        ks32[0] = longint'(P32);
        for (int k = 1; k < 26; k++) ks32[k] = (ks32[k-1] + longint'(Q32)) & m;
        for (int k = 0; k < 78; k++) begin
            a = rol((ks32[i] + a + b) & m, 3, 32);
            ks32[i] = a;
            b = rol((l[j] + a + b) & m, (a + b) & m, 32);
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    // ---------------- checking and drivers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic key_write(input int addr, input logic [31:0] data);
        key_we = 1'b1;
        key_addr = addr[4:0];
        key_wdata = data;
        @(posedge clk); #1;
        key_we = 1'b0;
    endtask

    task automatic start_block(input logic mode, input logic [63:0] blk);
        int n = 0;
        din_valid = 1'b1;
        din_mode = mode;
        din = blk;
        while (!din_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("din_ready_wait", 64'(din_ready), 64'd1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        din = '0;
    endtask

    task automatic finish_block(input int hold, output logic [63:0] res, output int lat);
        lat = 0;
        while (!dout_valid && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        res = dout;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_dout_stable", dout, res);
            chk("bp_dout_valid", 64'(dout_valid), 64'd1);
            chk("bp_din_ready_low", 64'(din_ready), 64'd0);
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        $display("txn w=32 out=%h lat=%0d", res, lat);
    endtask

    task automatic run16(input logic mode, input logic [31:0] blk, output logic [31:0] res, output int lat);
        int n = 0;
        d16_valid = 1'b1;
        d16_mode = mode;
        d16_in = blk;
        while (!d16_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w16_din_ready_wait", 64'(d16_ready), 64'd1);
        @(posedge clk); #1;
        d16_valid = 1'b0;
        lat = 0;
        while (!q16_valid && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        res = q16;
        q16_ready = 1'b1;
        @(posedge clk); #1;
        q16_ready = 1'b0;
        $display("txn w=16 mode=%0d in=%h out=%h lat=%0d", mode, blk, res, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pt, ct, rt, res2;
        logic [31:0] p16, c16, r16;
        int lat;

        // Reset behaviour
        #1;
        chk("rst_din_ready", 64'(din_ready), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_key_wr_err", 64'(key_wr_err), 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        @(posedge clk); #1;
        chk("rst_din_ready_held", 64'(din_ready), 64'd0);
        #6 clr = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_din_ready", 64'(din_ready), 64'd1);

        // Known-answer with the zero-key schedule
        expand_zero_key32();
        for (int k = 0; k < 26; k++) key_write(k, ks32[k][31:0]);
        start_block(MODE_ENC, 64'd0);
        finish_block(0, ct, lat);
        chk("kat_enc", ct, enc_model(64'd0, 32, 12));
        chk("kat_enc_latency", 64'(lat), 64'd12);
        start_block(MODE_DEC, ct);
        finish_block(0, rt, lat);
        chk("kat_dec", rt, 64'd0);
        chk("kat_dec_latency", 64'(lat), 64'd13);

        // Random round trips
        for (int k = 0; k < 1000; k++) begin
            pt = {$urandom, $urandom};
            start_block(MODE_ENC, pt);
            finish_block(0, ct, lat);
            chk("rnd_enc", ct, enc_model(pt, 32, 12));
            start_block(MODE_DEC, ct);
            finish_block(0, rt, lat);
            chk("rnd_dec", rt, pt);
        end

        // Backpressure: a second block is offered during the stall
        pt = {$urandom, $urandom};
        rt = {$urandom, $urandom};
        start_block(MODE_ENC, pt);
        din_valid = 1'b1;
        din_mode = MODE_DEC;
        din = rt;
        finish_block(7, ct, lat);
        chk("bp_result", ct, enc_model(pt, 32, 12));
        chk("bp_ready_after_handshake", 64'(din_ready), 64'd1);
        start_block(MODE_DEC, rt);
        finish_block(0, res2, lat);
        chk("bp_next_block", res2, dec_model(rt, 32, 12));

        // Key write while busy is dropped and flagged
        pt = {$urandom, $urandom};
        start_block(MODE_ENC, pt);
        @(posedge clk); #1;
        key_write(5, 32'hDEADBEEF);
        chk("busy_wr_err_pulse", 64'(key_wr_err), 64'd1);
        @(posedge clk); #1;
        chk("busy_wr_err_clear", 64'(key_wr_err), 64'd0);
        finish_block(0, ct, lat);
        chk("busy_wr_result", ct, enc_model(pt, 32, 12));
        pt = {$urandom, $urandom};
        start_block(MODE_ENC, pt);
        finish_block(0, ct, lat);
        chk("busy_wr_s5_kept", ct, enc_model(pt, 32, 12));

        // Out-of-range write in IDLE is ignored
        key_write(26, 32'h0BADF00D);
        chk("oor_wr_no_err", 64'(key_wr_err), 64'd0);
        pt = {$urandom, $urandom};
        start_block(MODE_DEC, pt);
        finish_block(0, rt, lat);
        chk("oor_wr_ignored", rt, dec_model(pt, 32, 12));

        // Write S[0] in the acceptance cycle: old whitening now, new value next block
        pt = {$urandom, $urandom};
        key_we = 1'b1;
        key_addr = 5'd0;
        key_wdata = 32'h1357_9BDF;
        start_block(MODE_ENC, pt);
        key_we = 1'b0;
        finish_block(0, ct, lat);
        chk("same_cycle_wr_old_s0", ct, enc_model(pt, 32, 12));
        ks32[0] = 64'h1357_9BDF;
        start_block(MODE_ENC, pt);
        finish_block(0, ct, lat);
        chk("same_cycle_wr_new_s0", ct, enc_model(pt, 32, 12));

        // Asynchronous reset at round 6
        pt = {$urandom, $urandom};
        start_block(MODE_ENC, pt);
        repeat (5) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        chk("arst_dout_valid", 64'(dout_valid), 64'd0);
        chk("arst_dout", dout, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_din_ready", 64'(din_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_no_valid", 64'(dout_valid), 64'd0);
        #2 clr = 1'b1;
        @(posedge clk); #1;
        chk("arst_release_ready", 64'(din_ready), 64'd1);
        chk("arst_release_no_valid", 64'(dout_valid), 64'd0);
        for (int k = 0; k < 26; k++) ks32[k] = 0;
        pt = {$urandom, $urandom};
        start_block(MODE_ENC, pt);
        finish_block(0, ct, lat);
        chk("arst_zero_table_enc", ct, enc_model(pt, 32, 12));
        chk("arst_zero_table_latency", 64'(lat), 64'd12);

        // W=16 R=8 instance
        for (int k = 0; k < 18; k++) begin
            ks16[k] = longint'($urandom_range(0, 65535));
            k16_we = 1'b1;
            k16_addr = 5'(k);
            k16_wdata = ks16[k][15:0];
            @(posedge clk); #1;
        end
        k16_we = 1'b0;
        run16(MODE_ENC, 32'h1234_5678, c16, lat);
        chk("w16_enc", 64'(c16), enc_model(64'h1234_5678, 16, 8));
        chk("w16_enc_latency", 64'(lat), 64'd8);
        run16(MODE_DEC, c16, r16, lat);
        chk("w16_dec", 64'(r16), 64'h1234_5678);
        chk("w16_dec_latency", 64'(lat), 64'd9);
        for (int k = 0; k < 20; k++) begin
            p16 = $urandom;
            run16(MODE_ENC, p16, c16, lat);
            chk("w16_rnd_enc", 64'(c16), enc_model(64'(p16), 16, 8));
            run16(MODE_DEC, c16, r16, lat);
            chk("w16_rnd_dec", 64'(r16), 64'(p16));
        end
        chk("w16_no_wr_err", 64'(k16_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
